apb_arb_master: RTL and testbench

Two-port APB master that shares one APB completer (the 16x8 register memory) between two requesters. Each requester issues single read/write transactions over a level req/one-cycle done handshake. The block:
- arbitrates round-robin,
- sequences the APB SETUP and ACCESS phases,
- waits on pready,
- aborts a stalled access after a programmable timeout.

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_rr_arbiter.sv | 38 +++
 rtl/apb_arb_master.sv | 151 +++++++++++++++
 tb/tb_apb_arb_master.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the two-port APB master: FSM state encoding and
// default bus/timeout parameters.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } apb_state_t;

   localparam int unsigned APB_ADDR_W      = 8;
   localparam int unsigned APB_DATA_W      = 8;
   localparam int unsigned APB_TIMEOUT_CYC = 16;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin arbiter. The pointer remembers the last granted
// requester and only moves when the master finishes a transfer.
module apb_rr_arbiter
   import apb_pkg::*;
(
   input  logic       pclk,
   input  logic       presetn,
   input  logic [1:0] i_req,
   input  logic       i_advance,
   input  logic       i_gnt_idx,
   output logic [1:0] o_gnt,
   output logic       o_last
);

   logic r_last;

   // Reset value 1 means "requester 1 was served last", so requester 0 wins first.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_last <= 1'b1;
      end else if (i_advance) begin
         r_last <= i_gnt_idx;
      end
   end

   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end

   assign o_last = r_last;

endmodule

// File: rtl/apb_arb_master.sv
// Two-port APB master: round-robin arbitration between two requesters,
// SETUP/ACCESS sequencing, pready wait with programmable timeout abort.
module apb_arb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W      = APB_ADDR_W,
   parameter int DATA_W      = APB_DATA_W,
   parameter int TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              done0,
   output logic              err0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              done1,
   output logic              err1,
   output logic [DATA_W-1:0] rdata1,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   output logic [1:0]        o_state
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   apb_state_t        r_state;
   apb_state_t        w_next;
   logic [1:0]        w_req;
   logic [1:0]        w_gnt;
   logic              w_advance;
   logic              w_last;
   logic              w_timeout;
   logic              r_gidx;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_paddr;
   logic              r_pwrite;
   logic [DATA_W-1:0] r_pwdata;
   logic [1:0]        r_done;
   logic [1:0]        r_err;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;

   assign w_req     = {req1, req0};
   assign w_advance = (r_state == DONE);
   assign w_timeout = (r_cnt == CNT_LAST);

   apb_rr_arbiter u_arb (
      .pclk      (pclk),
      .presetn   (presetn),
      .i_req     (w_req),
      .i_advance (w_advance),
      .i_gnt_idx (r_gidx),
      .o_gnt     (w_gnt),
      .o_last    (w_last)
   );

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (|w_req) w_next = SETUP;
         SETUP:   w_next = ACCESS;
         ACCESS:  if (pready || w_timeout) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // done/err are set on the ACCESS->DONE edge so they are high exactly in DONE.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_gidx   <= 1'b0;
         r_cnt    <= '0;
         r_paddr  <= '0;
         r_pwrite <= 1'b0;
         r_pwdata <= '0;
         r_done   <= 2'b00;
         r_err    <= 2'b00;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         r_done <= 2'b00;
         r_err  <= 2'b00;
         case (r_state)
            IDLE: begin
               if (|w_req) begin
                  r_gidx   <= w_gnt[1];
                  r_paddr  <= w_gnt[1] ? addr1  : addr0;
                  r_pwrite <= w_gnt[1] ? we1    : we0;
                  r_pwdata <= w_gnt[1] ? wdata1 : wdata0;
                  r_cnt    <= '0;
               end
            end
            ACCESS: begin
               if (pready) begin
                  r_done[r_gidx] <= 1'b1;
                  if (!r_pwrite) begin
                     if (r_gidx) r_rdata1 <= prdata;
                     else        r_rdata0 <= prdata;
                  end
               end else if (w_timeout) begin
                  r_done[r_gidx] <= 1'b1;
                  r_err[r_gidx]  <= 1'b1;
                  if (r_gidx) r_rdata1 <= '0;
                  else        r_rdata0 <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign psel    = (r_state == SETUP) || (r_state == ACCESS);
   assign penable = (r_state == ACCESS);
   assign pwrite  = r_pwrite;
   assign paddr   = r_paddr;
   assign pwdata  = r_pwdata;
   assign done0   = r_done[0];
   assign done1   = r_done[1];
   assign err0    = r_err[0];
   assign err1    = r_err[1];
   assign rdata0  = r_rdata0;
   assign rdata1  = r_rdata1;
   assign o_state = r_state;

   logic w_unused;
   assign w_unused = w_last;

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master with a 16x8 register-memory completer;
// completions are checked against an expected queue by a separate monitor.
module tb_apb_arb_master;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int TO = 4;
   localparam int EW = 1 + 1 + DW + 32;

   logic          pclk    = 1'b0;
   logic          presetn = 1'b0;
   logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic          done0, err0, done1, err1;
   logic [DW-1:0] rdata0, rdata1;
   logic          psel, penable, pwrite, pready;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata, prdata;
   logic [1:0]    state_dbg;

   logic [DW-1:0] mem [0:15];
   int            stall_n = 0;
   int            acc_cnt = 0;
   int            cyc = 0;
   int            total = 0;
   int            bad = 0;
   int            b = 0;
   int            n_en = 0;
   int            n_bad = 0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_e, mon_a;

   apb_arb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
      .pclk(pclk), .presetn(presetn),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .done0(done0), .err0(err0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .done1(done1), .err1(err1), .rdata1(rdata1),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .prdata(prdata), .pready(pready), .o_state(state_dbg)
   );

   // clock / reset / completer model
   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;
   always @(posedge pclk) acc_cnt <= penable ? acc_cnt + 1 : 0;
   assign pready = !(penable && (acc_cnt < stall_n));
   assign prdata = mem[paddr[3:0]];
   always @(posedge pclk) if (psel && penable && pready && pwrite) mem[paddr[3:0]] <= pwdata;

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic push_exp(input logic p, input logic e, input logic [DW-1:0] d, input int dc);
      exp_q.push_back({p, e, d, dc});
   endtask

   task automatic drive(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (p == 0) begin
         we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1;
      end else begin
         we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1;
      end
   endtask

   task automatic wait_done(input int p);
      int n = 0;
      do begin
         @(negedge pclk);
         n++;
      end while (!(p == 1 ? done1 : done0) && n < 40);
      if (!(p == 1 ? done1 : done0)) begin
         total++;
         bad++;
         $display("FAIL done_timeout port%0d: got no done within %0d cycles, want done", p, n);
      end
   endtask

   task automatic release_req(input int p);
      @(posedge pclk);
      #1;
      if (p == 0) req0 = 1'b0;
      else        req1 = 1'b0;
   endtask

   task automatic txn(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      drive(p, w, a, d);
      wait_done(p);
      release_req(p);
   endtask

   task automatic do_reset();
      @(negedge pclk);
      presetn = 1'b0;
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (2) @(negedge pclk);
      presetn = 1'b1;
      @(posedge pclk);
      #1;
   endtask

   // scoreboard monitor
   always @(negedge pclk) begin
      if (presetn && (done0 || done1)) begin
         total++;
         if (done0 && done1) begin
            bad++;
            $display("FAIL both_done: got done0=1 done1=1 at cyc %0d, want one-hot", cyc);
         end else if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done: got done0=%0b done1=%0b at cyc %0d, want none", done0, done1, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            mon_a = {done1, done1 ? err1 : err0, done1 ? rdata1 : rdata0, cyc};
            if (mon_a !== mon_e) begin
               bad++;
               $display("FAIL completion: got port=%0d err=%0b rdata=%02h cyc=%0d want port=%0d err=%0b rdata=%02h cyc=%0d",
                        mon_a[EW-1], mon_a[EW-2], mon_a[EW-3 -: DW], mon_a[31:0],
                        mon_e[EW-1], mon_e[EW-2], mon_e[EW-3 -: DW], mon_e[31:0]);
            end
         end
      end
   end

   initial begin
      // reset values
      repeat (2) @(negedge pclk);
      check("rst_psel", psel, 0);
      check("rst_penable", penable, 0);
      check("rst_pwrite", pwrite, 0);
      check("rst_paddr", paddr, 0);
      check("rst_pwdata", pwdata, 0);
      check("rst_done0", done0, 0);
      check("rst_done1", done1, 0);
      check("rst_err0", err0, 0);
      check("rst_err1", err1, 0);
      check("rst_rdata0", rdata0, 0);
      check("rst_rdata1", rdata1, 0);
      check("rst_state", state_dbg, 0);
      presetn = 1'b1;
      @(posedge pclk);
      #1;

      // write then read on requester 0; writes leave rdata untouched
      b = cyc; push_exp(0, 0, 8'h00, b + 3); txn(0, 1'b1, 8'h03, 8'hA5);
      b = cyc; push_exp(0, 0, 8'hA5, b + 3); txn(0, 1'b0, 8'h03, 8'h00);
      b = cyc; push_exp(0, 0, 8'hA5, b + 3); txn(0, 1'b1, 8'h01, 8'h11);
      b = cyc; push_exp(1, 0, 8'h00, b + 3); txn(1, 1'b1, 8'h02, 8'h22);

      // simultaneous reads right after reset: 0 first, 1 after one IDLE
      do_reset();
      b = cyc;
      push_exp(0, 0, 8'h11, b + 3);
      push_exp(1, 0, 8'h22, b + 7);
      fork
         txn(0, 1'b0, 8'h01, 8'h00);
         txn(1, 1'b0, 8'h02, 8'h00);
      join

      // both held for two transactions each: grants 0,1,0,1
      b = cyc;
      push_exp(0, 0, 8'hA5, b + 3);
      push_exp(1, 0, 8'h22, b + 7);
      push_exp(0, 0, 8'hA5, b + 11);
      push_exp(1, 0, 8'h22, b + 15);
      fork
         begin drive(0, 1'b0, 8'h03, 8'h00); wait_done(0); wait_done(0); release_req(0); end
         begin drive(1, 1'b0, 8'h02, 8'h00); wait_done(1); wait_done(1); release_req(1); end
      join

      // two wait states on a read
      stall_n = 2;
      b = cyc; push_exp(0, 0, 8'hA5, b + 5);
      fork
         txn(0, 1'b0, 8'h03, 8'h00);
         begin
            n_en = 0; n_bad = 0;
            for (int i = 0; i < 20; i++) begin
               @(negedge pclk);
               if (penable) n_en++;
               if (psel && paddr !== 8'h03) n_bad++;
               if (done0) break;
            end
         end
      join
      check("wait_penable_cycles", n_en, 3);
      check("wait_paddr_stable", n_bad, 0);

      // timeout on requester 1, then a normal request is accepted
      stall_n = 255;
      b = cyc; push_exp(1, 1, 8'h00, b + TO + 2); txn(1, 1'b0, 8'h02, 8'h00);
      stall_n = 0;
      b = cyc; push_exp(1, 0, 8'h22, b + 3); txn(1, 1'b0, 8'h02, 8'h00);

      // reset during ACCESS after a requester-0 grant
      b = cyc; push_exp(0, 0, 8'hA5, b + 3); txn(0, 1'b0, 8'h03, 8'h00);
      stall_n = 255;
      drive(0, 1'b0, 8'h01, 8'h00);
      for (int i = 0; i < 10; i++) begin
         @(negedge pclk);
         if (penable) break;
      end
      check("midrst_in_access", penable, 1);
      #2 presetn = 1'b0;
      #1;
      check("midrst_psel", psel, 0);
      check("midrst_penable", penable, 0);
      check("midrst_done0", done0, 0);
      req0 = 1'b0;
      stall_n = 0;
      repeat (2) @(negedge pclk);
      presetn = 1'b1;
      repeat (4) @(posedge pclk);
      #1;
      b = cyc;
      push_exp(0, 0, 8'h11, b + 3);
      push_exp(1, 0, 8'h22, b + 7);
      fork
         txn(0, 1'b0, 8'h01, 8'h00);
         txn(1, 1'b0, 8'h02, 8'h00);
      join

      // final report
      repeat (3) @(negedge pclk);
      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
